graph_trace_plotter: RTL and testbench
======================================

# graph_trace_plotter

Draws a scrolling waveform trace into the VGA pixel buffer. It consumes the modulated sample stream and the 24-bit trace colour held by the HPS-written colour PIO. For each accepted sample it erases the old segment in the current column, draws a vertical segment joining the previous sample to the new one, and advances the column with wrap-around. It sits downstream of the colour PIO and the sample source, and upstream of the VGA pixel-write adapter.

## Interface
- WIDTH, 160: screen columns; x range 0..WIDTH-1.
- HEIGHT, 120: screen rows; y range 0..HEIGHT-1.
- BG_COLOUR, 24'h000000: colour used for erase and clear.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- colour_in  in  24  trace colour from the colour PIO, RGB 8:8:8.
- sample_data  in  8  signed sample.
- sample_valid  in  1  sample offered.
- sample_ready  out  1  high only in IDLE.
- clear_req  in  1  one-cycle request to blank the screen.
- busy  out  1  high in every state except IDLE.
- pix_x  out  8  pixel column.
- pix_y  out  7  pixel row.
- pix_colour  out  24  pixel colour.
- pix_valid  out  1  pixel write offered.
- pix_ready  in  1  sink accepts a pixel when pix_valid && pix_ready.

## Operation
- Storage:
  - Per-column RAM of WIDTH entries, each {lo[6:0], hi[6:0]}, plus a WIDTH-bit col_valid vector.
  - Registers: cur_x, prev_y, prev_valid, latched sample y (y_new), latched colour, clr_pend.
- States are IDLE, CLEAR, LOAD, ERASE and DRAW.
- Mapping from sample to row:
  - y_raw = 59 - (sample_data >>> 1), computed signed at 9 bits.
  - Clamp y_raw to 0..HEIGHT-1. Example: -128 → 123 → 119; 127 → -4 → 0.
- CLEAR:
  - Writes BG_COLOUR to every pixel. y is the outer loop and x the inner loop, from (0,0) to (WIDTH-1,HEIGHT-1), which is 19200 writes.
  - On completion: col_valid=0, cur_x=0, prev_valid=0, clr_pend=0, then go to IDLE.
- IDLE:
  - If clear_req or clr_pend is set, go to CLEAR. Clear has priority over a sample offered in the same cycle; that sample is not accepted.
  - Otherwise, on sample_valid && sample_ready: latch y_new and colour_in (later colour_in changes do not affect this sample), then go to LOAD.
- LOAD: reads the RAM entry for cur_x (1 cycle). If col_valid[cur_x], go to ERASE; otherwise go to DRAW.
- ERASE: writes BG_COLOUR at (cur_x, y) for y = lo..hi ascending, then goes to DRAW.
- DRAW:
  - a = prev_valid ? prev_y : y_new. Writes the latched colour at (cur_x, y) for y = min(a,y_new)..max(a,y_new) ascending.
  - On completion:
    - Store {min,max} to the RAM and set col_valid[cur_x].
    - prev_y = y_new, prev_valid = 1.
    - cur_x = (cur_x == WIDTH-1) ? 0 : cur_x+1. The trace stays continuous across the wrap.
    - Go to IDLE.
- clear_req asserted outside IDLE sets clr_pend; the clear runs on the next IDLE. clr_pend cleared only when CLEAR completes.

## Timing
- Reset values:
  - state=CLEAR with counters at 0.
  - sample_ready=0, busy=1, pix_valid=0, pix_x=0, pix_y=0, pix_colour=0.
  - cur_x=0, prev_valid=0, col_valid=0, clr_pend=0.
- The screen is blanked automatically after reset; the first pix_valid is asserted on the first clk edge after reset_n deasserts.
- All outputs are registered.
- Pixel handshake:
  - While pix_valid && !pix_ready, pix_x, pix_y and pix_colour hold stable.
  - With pix_ready held high, the block issues one pixel per cycle with no gaps inside a state.
- Sample latency: accept at edge E, LOAD during cycle E+1, first pix_valid registered at edge E+2.
- Sample throughput: the next sample_ready follows the last DRAW transfer by 1 cycle.
- Reset mid-operation aborts immediately. The block re-enters CLEAR, and all pending work and RAM validity are discarded.

## Test plan
- Reset with pix_ready=1 → exactly 19200 BG writes in order (0,0),(1,0)…(159,119); sample_ready rises afterwards; busy drops.
- After clear, sample 0 with colour_in=24'hFF0000 → no ERASE; one write (0,59,FF0000); cur_x=1.
- Next sample 40 with colour_in=24'h00FF00 → 21 writes at x=1, y=39..59, all 00FF00.
- Sample -128 → y clamps to 119. Sample 127 → y clamps to 0; the segment spans the previous y to 0.
- 161 consecutive samples of 0 → the 161st erases (0,59) with BG, then draws (0,59). There is no out-of-range x.
- pix_ready toggled randomly during DRAW → outputs stable while stalled; no lost or duplicated pixel. clear_req pulsed during ERASE → the current sample completes, then a full 19200-write clear runs, then cur_x=0.

Source files
------------

// File: rtl/graph_trace_plotter.sv
// graph_trace_plotter: draws a scrolling sample trace into a pixel buffer.
// Each accepted sample erases the segment previously drawn in the current
// column, draws a vertical segment from the previous sample row to the new
// one, then advances the column with wrap-around. After reset the whole
// screen is blanked. All outputs are registered.
module graph_trace_plotter #(
    parameter int          WIDTH     = 160,
    parameter int          HEIGHT    = 120,
    parameter logic [23:0] BG_COLOUR = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] colour_in,
    input  logic [7:0]  sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic [23:0] pix_colour,
    output logic        pix_valid,
    input  logic        pix_ready
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_ERASE, S_DRAW} state_t;

    localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0]        Y_LAST = 7'(HEIGHT - 1);
    localparam logic signed [8:0] Y_MAX  = 9'(HEIGHT - 1);

    state_t             state_q, state_d;
    logic [7:0]         px_q, px_d;          // clear column counter
    logic [6:0]         py_q, py_d;          // row counter for all pixel loops
    logic               last_q, last_d;      // final pixel of the loop issued
    logic [7:0]         cur_x_q, cur_x_d;
    logic [6:0]         prev_y_q, prev_y_d;
    logic               prev_valid_q, prev_valid_d;
    logic [6:0]         y_new_q, y_new_d;
    logic [23:0]        colour_q, colour_d;
    logic               clr_pend_q, clr_pend_d;
    logic [WIDTH-1:0]   col_valid_q, col_valid_d;
    logic [6:0]         lo_q, lo_d, hi_q, hi_d;
    logic [7:0]         pix_x_q, pix_x_d;
    logic [6:0]         pix_y_q, pix_y_d;
    logic [23:0]        pix_colour_q, pix_colour_d;
    logic               pix_valid_q, pix_valid_d;
    logic               sample_ready_q, sample_ready_d;
    logic               busy_q, busy_d;

    logic [13:0]        col_ram [WIDTH];     // {lo, hi} of the segment in each column
    logic               ram_we;
    logic [13:0]        ram_rd;

    logic signed [8:0]  samp_ext, y_raw;
    logic [6:0]         y_map, a_y, draw_lo, draw_hi;
    logic               slot_free;

    // Map the signed sample to a clamped screen row.
    always_comb begin
        samp_ext = {sample_data[7], sample_data};
        y_raw    = 9'sd59 - (samp_ext >>> 1);
        if (y_raw < 9'sd0)       y_map = 7'd0;
        else if (y_raw > Y_MAX)  y_map = Y_LAST;
        else                     y_map = y_raw[6:0];
    end

    // Row span of the segment joining the previous sample to the latched one.
    always_comb begin
        a_y     = prev_valid_q ? prev_y_q : y_new_q;
        draw_lo = (a_y < y_new_q) ? a_y : y_new_q;
        draw_hi = (a_y < y_new_q) ? y_new_q : a_y;
    end

    assign ram_rd    = col_ram[cur_x_q];
    assign slot_free = !pix_valid_q || pix_ready;

    // Next-state and datapath decisions for the whole plotter.
    // NOTE: every signal gets its default first so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        px_d           = px_q;
        py_d           = py_q;
        last_d         = last_q;
        cur_x_d        = cur_x_q;
        prev_y_d       = prev_y_q;
        prev_valid_d   = prev_valid_q;
        y_new_d        = y_new_q;
        colour_d       = colour_q;
        clr_pend_d     = clr_pend_q;
        col_valid_d    = col_valid_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        pix_colour_d   = pix_colour_q;
        pix_valid_d    = pix_valid_q;
        ram_we         = 1'b0;

        if (clear_req && state_q != S_IDLE) clr_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d = S_CLEAR;
                    px_d    = '0;
                    py_d    = '0;
                    last_d  = 1'b0;
                end else if (sample_valid && sample_ready_q) begin
                    y_new_d  = y_map;
                    colour_d = colour_in;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                lo_d   = ram_rd[13:7];
                hi_d   = ram_rd[6:0];
                last_d = 1'b0;
                if (col_valid_q[cur_x_q]) begin
                    state_d = S_ERASE;
                    py_d    = ram_rd[13:7];
                end else begin
                    state_d = S_DRAW;
                    py_d    = draw_lo;
                end
            end
            S_CLEAR: begin
                if (slot_free) begin
                    if (!last_q) begin
                        pix_x_d      = px_q;
                        pix_y_d      = py_q;
                        pix_colour_d = BG_COLOUR;
                        pix_valid_d  = 1'b1;
                        if (px_q == X_LAST) begin
                            px_d = '0;
                            if (py_q == Y_LAST) last_d = 1'b1;
                            else                py_d   = py_q + 7'd1;
                        end else begin
                            px_d = px_q + 8'd1;
                        end
                    end else begin
                        pix_valid_d  = 1'b0;
                        last_d       = 1'b0;
                        col_valid_d  = '0;
                        cur_x_d      = '0;
                        prev_valid_d = 1'b0;
                        clr_pend_d   = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_ERASE: begin
                if (slot_free) begin
                    if (!last_q) begin
                        pix_x_d      = cur_x_q;
                        pix_y_d      = py_q;
                        pix_colour_d = BG_COLOUR;
                        pix_valid_d  = 1'b1;
                        if (py_q == hi_q) last_d = 1'b1;
                        else              py_d   = py_q + 7'd1;
                    end else begin
                        pix_valid_d = 1'b0;
                        last_d      = 1'b0;
                        py_d        = draw_lo;
                        state_d     = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (slot_free) begin
                    if (!last_q) begin
                        pix_x_d      = cur_x_q;
                        pix_y_d      = py_q;
                        pix_colour_d = colour_q;
                        pix_valid_d  = 1'b1;
                        if (py_q == draw_hi) last_d = 1'b1;
                        else                 py_d   = py_q + 7'd1;
                    end else begin
                        pix_valid_d          = 1'b0;
                        last_d               = 1'b0;
                        ram_we               = 1'b1;
                        col_valid_d[cur_x_q] = 1'b1;
                        prev_y_d             = y_new_q;
                        prev_valid_d         = 1'b1;
                        cur_x_d              = (cur_x_q == X_LAST) ? 8'd0 : cur_x_q + 8'd1;
                        state_d              = S_IDLE;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase

        sample_ready_d = (state_d == S_IDLE);
        busy_d         = (state_d != S_IDLE);
    end

    // State and output registers; reset restarts with a full-screen clear.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_CLEAR;
            px_q           <= '0;
            py_q           <= '0;
            last_q         <= 1'b0;
            cur_x_q        <= '0;
            prev_y_q       <= '0;
            prev_valid_q   <= 1'b0;
            y_new_q        <= '0;
            colour_q       <= '0;
            clr_pend_q     <= 1'b0;
            col_valid_q    <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_colour_q   <= '0;
            pix_valid_q    <= 1'b0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            px_q           <= px_d;
            py_q           <= py_d;
            last_q         <= last_d;
            cur_x_q        <= cur_x_d;
            prev_y_q       <= prev_y_d;
            prev_valid_q   <= prev_valid_d;
            y_new_q        <= y_new_d;
            colour_q       <= colour_d;
            clr_pend_q     <= clr_pend_d;
            col_valid_q    <= col_valid_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            pix_colour_q   <= pix_colour_d;
            pix_valid_q    <= pix_valid_d;
            sample_ready_q <= sample_ready_d;
            busy_q         <= busy_d;
        end
    end

    // Column segment memory, written when a segment finishes drawing.
    // NOTE: the RAM has no reset; col_valid marks which entries hold meaningful data.
    always_ff @(posedge clk) begin
        if (ram_we) col_ram[cur_x_q] <= {draw_lo, draw_hi};
    end

    assign sample_ready = sample_ready_q;
    assign busy         = busy_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_colour   = pix_colour_q;
    assign pix_valid    = pix_valid_q;

endmodule

// File: tb/tb_graph_trace_plotter.sv
// Directed testbench for graph_trace_plotter: records every accepted pixel
// write and compares against hand-computed segments and clear sequences.
module tb_graph_trace_plotter;

    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] colour_in = '0;
    logic [7:0]  sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        clear_req = 1'b0;
    logic        pix_ready = 1'b1;
    logic        sample_ready, busy, pix_valid;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [23:0] pix_colour;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] c;
    } pix_t;

    pix_t wq[$];
    pix_t last_pix;
    bit   last_stall = 1'b0;
    bit   rand_ready = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_bad = 0;
    int   range_bad = 0;

    graph_trace_plotter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .colour_in    (colour_in),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clear_req    (clear_req),
        .busy         (busy),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready)
    );

    always #5 clk = ~clk;

    // Sink readiness: always ready, or random while rand_ready is set.
    always @(posedge clk) begin
        #1;
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Pixel sink model: capture transfers, watch stall stability and range.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_stall = 1'b0;
        end else begin
            if (last_stall && (!pix_valid || {pix_x, pix_y, pix_colour} != last_pix))
                stall_bad++;
            if (pix_valid && pix_ready) begin
                wq.push_back({pix_x, pix_y, pix_colour});
                if (pix_x > 8'd159 || pix_y > 7'd119) range_bad++;
            end
            last_stall = pix_valid && !pix_ready;
            last_pix   = {pix_x, pix_y, pix_colour};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        @(negedge clk);
        while (!sample_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) check({tag, "_timeout"}, 64'(sample_ready), 64'd1);
    endtask

    task automatic send_sample(input logic [7:0] data, input logic [23:0] colour);
        wait_idle("send", 25000);
        sample_data  = data;
        colour_in    = colour;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    // Entries start.. must be column x, rows ylo..yhi ascending, colour c.
    task automatic check_seg(input string tag, input int start, input int x,
                             input int ylo, input int yhi, input logic [23:0] c);
        int   bad = 0;
        pix_t e;
        for (int y = ylo; y <= yhi; y++) begin
            int i = start + y - ylo;
            e.x = 8'(x);
            e.y = 7'(y);
            e.c = c;
            if (i >= wq.size() || wq[i] !== e) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    // Entries base..base+19199 must be a raster-order background fill.
    task automatic check_clear(input string tag, input int base);
        int   bad = 0;
        pix_t e;
        for (int i = 0; i < 19200; i++) begin
            e.x = 8'(i % 160);
            e.y = 7'(i / 160);
            e.c = BG;
            if (base + i >= wq.size() || wq[base + i] !== e) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and automatic clear.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_valid", 64'(pix_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ready", 64'(sample_ready), 64'd0);
        check("rst_pix_xyc", {pix_x, pix_y, pix_colour}, 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 check("first_pix", {pix_valid, pix_x, pix_y}, {1'b1, 15'd0});
        wait_idle("clear0", 25000);
        check("clear0_count", 64'(wq.size()), 64'd19200);
        check_clear("clear0_order", 0);
        check("clear0_busy", 64'(busy), 64'd0);

        // Sample 0: single pixel at (0,59), colour latched at accept.
        wq.delete();
        send_sample(8'h00, 24'hFF0000);
        colour_in = 24'h123456;
        @(posedge clk);
        #1 check("lat_load", 64'(pix_valid), 64'd0);
        @(posedge clk);
        #1 check("lat_first", 64'(pix_valid), 64'd1);
        wait_idle("s0", 200);
        check("s0_count", 64'(wq.size()), 64'd1);
        check_seg("s0_pix", 0, 0, 59, 59, 24'hFF0000);

        // Sample 40 -> row 39, segment 39..59 in column 1.
        wq.delete();
        send_sample(8'd40, 24'h00FF00);
        wait_idle("s40", 200);
        check("s40_count", 64'(wq.size()), 64'd21);
        check_seg("s40_seg", 0, 1, 39, 59, 24'h00FF00);

        // Clamping: -128 -> 119 (col 2), then 127 -> 0 (col 3).
        wq.delete();
        send_sample(8'h80, 24'h0000FF);
        wait_idle("sneg", 400);
        check("sneg_count", 64'(wq.size()), 64'd81);
        check_seg("sneg_seg", 0, 2, 39, 119, 24'h0000FF);
        wq.delete();
        send_sample(8'h7F, 24'hFFFF00);
        wait_idle("spos", 400);
        check("spos_count", 64'(wq.size()), 64'd120);
        check_seg("spos_seg", 0, 3, 0, 119, 24'hFFFF00);

        // Explicit clear, then 161 zero samples to exercise the wrap.
        wq.delete();
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        wait_idle("clear1", 25000);
        check("clear1_count", 64'(wq.size()), 64'd19200);
        check_clear("clear1_order", 0);
        wq.delete();
        for (int k = 0; k < 161; k++) send_sample(8'h00, 24'h0000FF);
        wait_idle("wrap", 200);
        check("wrap_count", 64'(wq.size()), 64'd162);
        begin
            int   bad = 0;
            pix_t e;
            for (int i = 0; i < 160; i++) begin
                e.x = 8'(i);
                e.y = 7'd59;
                e.c = 24'h0000FF;
                if (i >= wq.size() || wq[i] !== e) bad++;
            end
            check("wrap_cols", 64'(bad), 64'd0);
        end
        check_seg("wrap_erase", 160, 0, 59, 59, BG);
        check_seg("wrap_draw", 161, 0, 59, 59, 24'h0000FF);
        check("wrap_range", 64'(range_bad), 64'd0);

        // Random backpressure on erase+draw in columns 1 and 2.
        wq.delete();
        rand_ready = 1'b1;
        send_sample(8'h7F, 24'hABCDEF);
        send_sample(8'h80, 24'h00FF00);
        wait_idle("bp", 4000);
        rand_ready = 1'b0;
        check("bp_count", 64'(wq.size()), 64'd182);
        check_seg("bp_erase1", 0, 1, 59, 59, BG);
        check_seg("bp_draw1", 1, 1, 0, 59, 24'hABCDEF);
        check_seg("bp_erase2", 61, 2, 59, 59, BG);
        check_seg("bp_draw2", 62, 2, 0, 119, 24'h00FF00);
        check("bp_stall_hold", 64'(stall_bad), 64'd0);

        // clear_req during ERASE: sample finishes, then full clear.
        repeat (3) @(posedge clk);
        @(negedge clk);
        wq.delete();
        send_sample(8'h00, 24'hFF00FF);
        @(posedge clk);
        #1 clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        wait_idle("pend_a", 400);
        wait_idle("pend_b", 25000);
        check("pend_count", 64'(wq.size()), 64'd19262);
        check_seg("pend_erase", 0, 3, 59, 59, BG);
        check_seg("pend_draw", 1, 3, 59, 119, 24'hFF00FF);
        check_clear("pend_clear", 62);
        wq.delete();
        send_sample(8'h00, 24'h00FF00);
        wait_idle("pend_x0", 200);
        check("pend_x0_count", 64'(wq.size()), 64'd1);
        check_seg("pend_x0_pix", 0, 0, 59, 59, 24'h00FF00);

        // Reset in the middle of a draw discards everything.
        send_sample(8'h7F, 24'h0000FF);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pix_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd1);
        wq.delete();
        @(negedge clk) reset_n = 1'b1;
        wait_idle("clear2", 25000);
        check("clear2_count", 64'(wq.size()), 64'd19200);
        wq.delete();
        send_sample(8'h00, 24'hFFFFFF);
        wait_idle("post_rst", 200);
        check("post_rst_count", 64'(wq.size()), 64'd1);
        check_seg("post_rst_pix", 0, 0, 59, 59, 24'hFFFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
